traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//   Parametrised four-phase intersection controller: main, main-left arrow, cross, cross-left arrow.
//   Sensor demand is latched; phases with no demand are skipped; every phase change passes through yellow and all-red.
//   Internal prescaler divides clk to a 1-s tick; per-phase countdown feeds the existing 7-seg decoder.
// PARAMETERS
//   TICK_COUNT  49999999  tick period = TICK_COUNT+1 clk cycles
//   CNT_W       4         countdown width; all *_T values must be in range 1..2**CNT_W-1
//   GREEN_T     5         min main green / cross green dwell, ticks
//   YELLOW_T    3         through-movement yellow, ticks
//   ARROW_T     4         green-arrow dwell, ticks
//   ARROW_Y_T   2         yellow-arrow dwell, ticks
//   ALLRED_T    2         all-red clearance, ticks
// PORTS
//   clk          in   1      system clock
//   reset_n      in   1      asynchronous reset, active low
//   sensors      in   5      [0] left main, [1] left cross, [2] cross traffic, [3] walk main, [4] walk cross
//   main_lights  out  5      {red,yellow,green,yellow_arrow,green_arrow}, one-hot
//   cross_lights out  5      same encoding as main_lights
//   walk_main    out  1      pedestrian walk, main direction
//   walk_cross   out  1      pedestrian walk, cross direction
//   count        out  CNT_W  ticks remaining in current phase
//   state_out    out  4      state code, for debug/display
// BEHAVIOUR
//   Reset (async, reset_n=0): state=ALL_STOP, count=ALLRED_T, prescaler=0, all requests=0.
//     main_lights=cross_lights=5'b10000; walk_main=walk_cross=0. next_phase=MAIN_GO.
//   Prescaler: tick is a 1-clk pulse when prescaler==TICK_COUNT; prescaler then wraps to 0.
//     Prescaler free-runs; a state change does not reset it.
//   States (codes):
//     MAIN_GO=0, MAIN_Y=1, MARW_GO=2, MARW_Y=3, CROSS_GO=4, CROSS_Y=5, CARW_GO=6, CARW_Y=7, ALL_STOP=8.
//     Codes 9-15 are illegal and go to ALL_STOP on the next clk.
//   Lights are a Moore decode of the state register; there is no latency beyond the state register.
//     GO: active side green (00100); Y: active side yellow (01000); ARW_GO: green_arrow (00001).
//     ARW_Y: yellow_arrow (00010). Inactive side is red (10000). ALL_STOP: both sides red.
//   Requests (sticky, one bit each):
//     rq_marw = s[0]; rq_carw = s[1]; rq_cross = s[2]|s[4]; rq_wm = s[3]; rq_wc = s[4].
//     A request is set on any clk where its sensor is high.
//     A request is cleared on the clk its serving GO state is entered: MARW_GO clears rq_marw,
//       CROSS_GO clears rq_cross and rq_wc, CARW_GO clears rq_carw, MAIN_GO clears rq_wm.
//     Sensors are masked while their serving GO state is active. Clear wins over a simultaneous set.
//   Walk outputs:
//     walk_main=1 throughout MAIN_GO if rq_wm was set at entry. walk_cross likewise in CROSS_GO with rq_wc.
//   Countdown:
//     count loads the phase duration on state entry and decrements only on tick.
//     On a tick with count==1 the phase ends: the next state is entered and the next duration loaded in the same clk.
//   MAIN_GO is the rest phase. On a tick with count==1 and no pending rq_marw, rq_cross or rq_carw:
//     count goes to 0 and holds there. Light stays green.
//     While count==0, the first tick that sees any of those requests ends the phase.
//   Sequencing:
//     Every GO is followed by its Y, and every Y by ALL_STOP.
//     After ALL_STOP, next_phase is the first phase, in ring order MAIN_GO -> MARW_GO -> CROSS_GO -> CARW_GO, that:
//       - comes strictly after the last GO served, and
//       - has a pending request.
//     MAIN_GO is always eligible. next_phase is evaluated at the ALL_STOP exit tick.
//   Durations: GO=GREEN_T, Y=YELLOW_T, ARW_GO=ARROW_T, ARW_Y=ARROW_Y_T, ALL_STOP=ALLRED_T.
//   state_out = state code; count is reported raw.
// TESTING (bench uses TICK_COUNT=3, i.e. tick every 4 clk)
//   Reset -> lights 10000/10000 and count=2. After 2 ticks: MAIN_GO, count=5, main=00100, cross=10000.
//   No sensors for 40 ticks -> state stays 0; count reaches 0 after 5 ticks and holds there; no yellow is ever shown.
//   1-clk pulse on s[2] while resting -> next tick enters MAIN_Y (count=3).
//     Sequence is then ALL_STOP(2), CROSS_GO(5), CROSS_Y(3), ALL_STOP(2), MAIN_GO. Both arrows are skipped.
//   s[0] and s[1] held high together from rest -> ring order:
//     MARW_GO, MARW_Y, ALL_STOP, CARW_GO, CARW_Y, ALL_STOP, MAIN_GO. CROSS_GO is skipped.
//   s[4] pulse during MARW_GO -> after MARW_Y and ALL_STOP: CROSS_GO with walk_cross=1 for 5 ticks; rq_wc cleared.
//   reset_n low mid CROSS_GO (between clk edges) -> outputs go to reset values immediately, without waiting for clk.
//     All requests cleared; after release, ALL_STOP runs 2 ticks then MAIN_GO.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Four-phase intersection controller: main through, main left arrow,
//   cross through, cross left arrow. Sensor demand is latched into sticky
//   requests; phases without demand are skipped. Every phase change runs
//   GO -> Y -> ALL_STOP, and ALL_STOP picks the next phase in ring order.
//   A free-running prescaler produces a one-clk tick every TICK_COUNT+1
//   clocks; all phase timing is counted in ticks.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous reset, active low
//   sensors[4:0] [0] left main, [1] left cross, [2] cross traffic,
//                [3] walk main, [4] walk cross
//   main_lights  {red,yellow,green,yellow_arrow,green_arrow}, one-hot
//   cross_lights same encoding as main_lights
//   walk_main    pedestrian walk, main direction (held through MAIN_GO)
//   walk_cross   pedestrian walk, cross direction (held through CROSS_GO)
//   count        ticks remaining in the current phase (raw)
//   state_out    state code, for debug/display
module traffic_phase_ctrl #(
  parameter int TICK_COUNT = 49999999,
  parameter int CNT_W      = 4,
  parameter int GREEN_T    = 5,
  parameter int YELLOW_T   = 3,
  parameter int ARROW_T    = 4,
  parameter int ARROW_Y_T  = 2,
  parameter int ALLRED_T   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       sensors,
  output logic [4:0]       main_lights,
  output logic [4:0]       cross_lights,
  output logic             walk_main,
  output logic             walk_cross,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       state_out
);

  typedef enum logic [3:0] {
    MAIN_GO  = 4'd0,
    MAIN_Y   = 4'd1,
    MARW_GO  = 4'd2,
    MARW_Y   = 4'd3,
    CROSS_GO = 4'd4,
    CROSS_Y  = 4'd5,
    CARW_GO  = 4'd6,
    CARW_Y   = 4'd7,
    ALL_STOP = 4'd8
  } state_t;

  localparam int PRE_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_COUNT);

  localparam logic [CNT_W-1:0] GREEN_C   = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_C  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ARROW_C   = CNT_W'(ARROW_T);
  localparam logic [CNT_W-1:0] ARROW_Y_C = CNT_W'(ARROW_Y_T);
  localparam logic [CNT_W-1:0] ALLRED_C  = CNT_W'(ALLRED_T);

  localparam logic [4:0] L_RED  = 5'b10000;
  localparam logic [4:0] L_YEL  = 5'b01000;
  localparam logic [4:0] L_GRN  = 5'b00100;
  localparam logic [4:0] L_YARW = 5'b00010;
  localparam logic [4:0] L_GARW = 5'b00001;

  // Index of the last GO phase served: 0 main, 1 main arrow, 2 cross, 3 cross arrow.
  localparam logic [1:0] IDX_MAIN  = 2'd0;
  localparam logic [1:0] IDX_MARW  = 2'd1;
  localparam logic [1:0] IDX_CROSS = 2'd2;
  localparam logic [1:0] IDX_CARW  = 2'd3;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] count_d;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic             rq_marw, rq_carw, rq_cross, rq_wm, rq_wc;
  logic [1:0]       last_go;
  logic             walk_main_q, walk_cross_q;
  state_t           next_go;
  logic [CNT_W-1:0] next_go_t;
  logic             any_req;
  logic             entering;

  assign tick      = (prescaler == PRE_MAX);
  assign any_req   = rq_marw | rq_cross | rq_carw;
  assign entering  = (state_d != state);
  assign state_out = state;
  assign walk_main  = walk_main_q;
  assign walk_cross = walk_cross_q;

  // Ring search starting strictly after the last GO served. MAIN_GO is the
  // fallback because it is always eligible and closes the ring.
  always_comb begin
    next_go   = MAIN_GO;
    next_go_t = GREEN_C;
    if (last_go == IDX_MAIN && rq_marw) begin
      next_go   = MARW_GO;
      next_go_t = ARROW_C;
    end else if (last_go <= IDX_MARW && rq_cross) begin
      next_go   = CROSS_GO;
      next_go_t = GREEN_C;
    end else if (last_go <= IDX_CROSS && rq_carw) begin
      next_go   = CARW_GO;
      next_go_t = ARROW_C;
    end
  end

  // Next state / countdown. The count only moves on a tick; a phase ends on
  // the tick that sees count==1 and the next duration loads in that clk.
  // MAIN_GO is the rest phase: with no demand it parks at count 0 and keeps
  // the green, leaving on the first tick that sees a pending request.
  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      MAIN_GO: begin
        if (tick) begin
          if (count <= CNT_W'(1)) begin
            if (any_req) begin
              state_d = MAIN_Y;
              count_d = YELLOW_C;
            end else begin
              count_d = '0;
            end
          end else begin
            count_d = count - CNT_W'(1);
          end
        end
      end
      MARW_GO, CROSS_GO, CARW_GO,
      MAIN_Y, MARW_Y, CROSS_Y, CARW_Y, ALL_STOP: begin
        if (tick) begin
          if (count <= CNT_W'(1)) begin
            case (state)
              MARW_GO:  begin state_d = MARW_Y;  count_d = ARROW_Y_C; end
              CROSS_GO: begin state_d = CROSS_Y; count_d = YELLOW_C;  end
              CARW_GO:  begin state_d = CARW_Y;  count_d = ARROW_Y_C; end
              ALL_STOP: begin state_d = next_go; count_d = next_go_t; end
              default:  begin state_d = ALL_STOP; count_d = ALLRED_C; end
            endcase
          end else begin
            count_d = count - CNT_W'(1);
          end
        end
      end
      // Codes 9-15 recover to ALL_STOP on the next clk without waiting for a tick.
      default: begin
        state_d = ALL_STOP;
        count_d = ALLRED_C;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ALL_STOP;
      count        <= ALLRED_C;
      prescaler    <= '0;
      rq_marw      <= 1'b0;
      rq_carw      <= 1'b0;
      rq_cross     <= 1'b0;
      rq_wm        <= 1'b0;
      rq_wc        <= 1'b0;
      // Last served = cross arrow, so the first ALL_STOP exit selects MAIN_GO.
      last_go      <= IDX_CARW;
      walk_main_q  <= 1'b0;
      walk_cross_q <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      state     <= state_d;
      count     <= count_d;

      if (entering) begin
        case (state_d)
          MAIN_GO:  last_go <= IDX_MAIN;
          MARW_GO:  last_go <= IDX_MARW;
          CROSS_GO: last_go <= IDX_CROSS;
          CARW_GO:  last_go <= IDX_CARW;
          default:  last_go <= last_go;
        endcase
      end

      // Sticky requests: sensors are ignored while the serving GO is active,
      // and entry into the serving GO clears the request even if the sensor
      // is high in that same clk.
      rq_marw  <= (entering && state_d == MARW_GO) ? 1'b0
                : rq_marw | (sensors[0] && state != MARW_GO);
      rq_carw  <= (entering && state_d == CARW_GO) ? 1'b0
                : rq_carw | (sensors[1] && state != CARW_GO);
      rq_cross <= (entering && state_d == CROSS_GO) ? 1'b0
                : rq_cross | ((sensors[2] | sensors[4]) && state != CROSS_GO);
      rq_wc    <= (entering && state_d == CROSS_GO) ? 1'b0
                : rq_wc | (sensors[4] && state != CROSS_GO);
      rq_wm    <= (entering && state_d == MAIN_GO) ? 1'b0
                : rq_wm | (sensors[3] && state != MAIN_GO);

      // Walk is decided once at GO entry and held for the whole GO.
      if (entering && state_d == MAIN_GO) begin
        walk_main_q <= rq_wm;
      end else if (state_d != MAIN_GO) begin
        walk_main_q <= 1'b0;
      end
      if (entering && state_d == CROSS_GO) begin
        walk_cross_q <= rq_wc;
      end else if (state_d != CROSS_GO) begin
        walk_cross_q <= 1'b0;
      end
    end
  end

  // Moore light decode straight from the state register.
  always_comb begin
    main_lights  = L_RED;
    cross_lights = L_RED;
    case (state)
      MAIN_GO:  main_lights  = L_GRN;
      MAIN_Y:   main_lights  = L_YEL;
      MARW_GO:  main_lights  = L_GARW;
      MARW_Y:   main_lights  = L_YARW;
      CROSS_GO: cross_lights = L_GRN;
      CROSS_Y:  cross_lights = L_YEL;
      CARW_GO:  cross_lights = L_GARW;
      CARW_Y:   cross_lights = L_YARW;
      default: begin
        main_lights  = L_RED;
        cross_lights = L_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with a 4-clk tick. A negedge monitor pops one
// expected phase record each time state_out changes and checks the record
// plus the length of the phase just left.
module tb_traffic_phase_ctrl;

  localparam logic [3:0] S_MAIN_GO  = 4'd0;
  localparam logic [3:0] S_MAIN_Y   = 4'd1;
  localparam logic [3:0] S_MARW_GO  = 4'd2;
  localparam logic [3:0] S_MARW_Y   = 4'd3;
  localparam logic [3:0] S_CROSS_GO = 4'd4;
  localparam logic [3:0] S_CROSS_Y  = 4'd5;
  localparam logic [3:0] S_CARW_GO  = 4'd6;
  localparam logic [3:0] S_CARW_Y   = 4'd7;
  localparam logic [3:0] S_ALL_STOP = 4'd8;
  localparam int CLK_PER_TICK = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] sensors;
  logic [4:0] main_lights, cross_lights;
  logic       walk_main, walk_cross;
  logic [3:0] count;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;

  // Record: {state, entry count, main, cross, walk_main, walk_cross}
  logic [19:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          clks_in_phase;
  int          exp_len;
  bit          len_valid;
  logic [3:0]  prev_state;
  logic [19:0] mon_item;

  traffic_phase_ctrl #(.TICK_COUNT(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sensors      (sensors),
    .main_lights  (main_lights),
    .cross_lights (cross_lights),
    .walk_main    (walk_main),
    .walk_cross   (walk_cross),
    .count        (count),
    .state_out    (state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_item(input logic [3:0] st, input logic wm, input logic wc);
    logic [3:0] dur;
    logic [4:0] m;
    logic [4:0] c;
    m = 5'b10000;
    c = 5'b10000;
    dur = 4'd2;
    case (st)
      S_MAIN_GO:  begin dur = 4'd5; m = 5'b00100; end
      S_MAIN_Y:   begin dur = 4'd3; m = 5'b01000; end
      S_MARW_GO:  begin dur = 4'd4; m = 5'b00001; end
      S_MARW_Y:   begin dur = 4'd2; m = 5'b00010; end
      S_CROSS_GO: begin dur = 4'd5; c = 5'b00100; end
      S_CROSS_Y:  begin dur = 4'd3; c = 5'b01000; end
      S_CARW_GO:  begin dur = 4'd4; c = 5'b00001; end
      S_CARW_Y:   begin dur = 4'd2; c = 5'b00010; end
      default:    dur = 4'd2;
    endcase
    return {st, dur, m, c, wm, wc};
  endfunction

  function automatic logic [19:0] obs_now();
    return {state_out, count, main_lights, cross_lights, walk_main, walk_cross};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (state_out != prev_state) begin
        if (len_valid) check_eq("phase_len", clks_in_phase, exp_len);
        if (exp_q.size() == 0) begin
          check_eq("extra_phase", obs_now(), 20'hFFFFF);
          len_valid = 1'b0;
        end else begin
          mon_item = exp_q.pop_front();
          check_eq("phase", obs_now(), mon_item);
          exp_len   = int'(mon_item[15:12]) * CLK_PER_TICK;
          len_valid = (mon_item[19:16] != S_MAIN_GO);
        end
        clks_in_phase = 1;
        prev_state    = state_out;
      end else begin
        clks_in_phase++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [3:0] st, input logic wm = 1'b0, input logic wc = 1'b0);
    exp_q.push_back(exp_item(st, wm, wc));
  endtask

  task automatic pulse(input int idx);
    @(negedge clk);
    sensors[idx] = 1'b1;
    @(negedge clk);
    sensors[idx] = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget);
    int n = 0;
    while (state_out != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_state", state_out, target);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic assert_reset_mid_cycle();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    reset_n = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset_n       = 1'b1;
    prev_state    = S_ALL_STOP;
    clks_in_phase = 0;
    exp_len       = ALLRED_CLKS();
    len_valid     = 1'b1;
    mon_en        = 1'b1;
  endtask

  function automatic int ALLRED_CLKS();
    return 2 * CLK_PER_TICK;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    sensors = 5'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", obs_now(), exp_item(S_ALL_STOP, 1'b0, 1'b0));
    check_eq("reset_count", count, 4'd2);

    // Reset release: ALL_STOP for 2 ticks, then MAIN_GO.
    push(S_MAIN_GO);
    release_reset();
    wait_state(S_MAIN_GO, 40);

    // Rest: no sensors for 40 ticks; count parks at 0, green stays.
    repeat (19) @(negedge clk);
    check_eq("rest_count_1", count, 4'd1);
    @(negedge clk);
    check_eq("rest_count_0", count, 4'd0);
    repeat (140) @(negedge clk);
    check_eq("rest_state", state_out, S_MAIN_GO);
    check_eq("rest_count_hold", count, 4'd0);
    check_eq("rest_main_green", main_lights, 5'b00100);

    // Cross traffic pulse from rest: both arrows skipped.
    push(S_MAIN_Y); push(S_ALL_STOP); push(S_CROSS_GO);
    push(S_CROSS_Y); push(S_ALL_STOP); push(S_MAIN_GO);
    pulse(2);
    wait_state(S_MAIN_Y, 6);
    wait_drain(400);

    // Both arrow sensors held: MARW, then CARW, CROSS skipped.
    push(S_MAIN_Y); push(S_ALL_STOP); push(S_MARW_GO); push(S_MARW_Y);
    push(S_ALL_STOP); push(S_CARW_GO); push(S_CARW_Y); push(S_ALL_STOP);
    push(S_MAIN_GO);
    @(negedge clk);
    sensors[0] = 1'b1;
    sensors[1] = 1'b1;
    wait_state(S_MARW_GO, 400);
    sensors[0] = 1'b0;
    wait_state(S_CARW_GO, 400);
    sensors[1] = 1'b0;
    wait_drain(400);

    // Walk cross requested during MARW_GO; walk main requested during CROSS_GO.
    push(S_MAIN_Y); push(S_ALL_STOP); push(S_MARW_GO); push(S_MARW_Y);
    push(S_ALL_STOP); push(S_CROSS_GO, 1'b0, 1'b1); push(S_CROSS_Y);
    push(S_ALL_STOP); push(S_MAIN_GO, 1'b1, 1'b0);
    pulse(0);
    wait_state(S_MARW_GO, 400);
    pulse(4);
    wait_state(S_CROSS_GO, 400);
    pulse(3);
    repeat (17) @(negedge clk);
    check_eq("walk_cross_held", walk_cross, 1'b1);
    check_eq("cross_go_last_tick", {state_out, count}, {S_CROSS_GO, 4'd1});
    wait_drain(400);

    // Both walk requests were consumed: plain cross cycle, no walk lights.
    push(S_MAIN_Y); push(S_ALL_STOP); push(S_CROSS_GO);
    push(S_CROSS_Y); push(S_ALL_STOP); push(S_MAIN_GO);
    pulse(2);
    wait_drain(400);

    // Async reset mid CROSS_GO with a main-arrow request pending.
    push(S_MAIN_Y); push(S_ALL_STOP); push(S_CROSS_GO);
    pulse(2);
    wait_state(S_CROSS_GO, 400);
    pulse(0);
    repeat (3) @(negedge clk);
    assert_reset_mid_cycle();
    #1;
    check_eq("async_reset_outputs", obs_now(), exp_item(S_ALL_STOP, 1'b0, 1'b0));
    check_eq("async_reset_count", count, 4'd2);
    repeat (3) @(negedge clk);
    push(S_MAIN_GO);
    release_reset();
    wait_state(S_MAIN_GO, 40);
    // The pending arrow request was wiped, so MAIN_GO rests.
    repeat (24) @(negedge clk);
    check_eq("post_reset_rest", {state_out, count}, {S_MAIN_GO, 4'd0});
    wait_drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
